// File: rtl/sum_accum.sv
// sum_accum: accumulates one row of FP16 partial sums and presents the total with its beat count.
// Optional macro SUM_ACCUM_SAT_EN: finite overflow saturates to max finite instead of infinity.
`timescale 1ns/1ps
module sum_accum #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [15:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [CNT_W-1:0] out_beats
);

`ifdef SUM_ACCUM_SAT_EN
    localparam logic [14:0] OVF_MAG = 15'h7BFF;
`else
    localparam logic [14:0] OVF_MAG = 15'h7C00;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [15:0]      acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    // Binary16 add, round-to-nearest-even; subnormals flushed on input and output.
    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        logic              a_zero, b_zero, a_spec, b_spec, a_nan, b_nan, same, found, up;
        logic [10:0]       ma, mb, m_big, m_sml;
        logic [4:0]        e_big, e_sml, d, lz;
        logic              s_big;
        logic [24:0]       sh;
        logic [13:0]       big14, sml14, diff, norm;
        logic [14:0]       sum;
        logic [11:0]       mant_r;
        logic [9:0]        frac;
        logic signed [7:0] e_res;
        logic [15:0]       res;

        a_zero = (a[14:10] == 5'd0);
        b_zero = (b[14:10] == 5'd0);
        a_spec = (a[14:10] == 5'h1F);
        b_spec = (b[14:10] == 5'h1F);
        a_nan  = a_spec && (a[9:0] != 10'd0);
        b_nan  = b_spec && (b[9:0] != 10'd0);
        ma     = a_zero ? 11'd0 : {1'b1, a[9:0]};
        mb     = b_zero ? 11'd0 : {1'b1, b[9:0]};
        same   = (a[15] == b[15]);

        s_big  = 1'b0;
        e_big  = 5'd0;
        e_sml  = 5'd0;
        m_big  = 11'd0;
        m_sml  = 11'd0;
        d      = 5'd0;
        lz     = 5'd0;
        found  = 1'b0;
        sh     = 25'd0;
        big14  = 14'd0;
        sml14  = 14'd0;
        diff   = 14'd0;
        norm   = 14'd0;
        sum    = 15'd0;
        up     = 1'b0;
        mant_r = 12'd0;
        frac   = 10'd0;
        e_res  = 8'sd0;
        res    = 16'h0000;

        if (a_nan || b_nan || (a_spec && b_spec && !same)) begin
            res = 16'h7E00;
        end else if (a_spec) begin
            res = a;
        end else if (b_spec) begin
            res = b;
        end else if (a_zero && b_zero) begin
            res = {a[15] & b[15], 15'd0};
        end else begin
            if ({a[14:10], ma} >= {b[14:10], mb}) begin
                s_big = a[15];
                e_big = a[14:10];
                m_big = ma;
                e_sml = b[14:10];
                m_sml = mb;
            end else begin
                s_big = b[15];
                e_big = b[14:10];
                m_big = mb;
                e_sml = a[14:10];
                m_sml = ma;
            end
            // Three extra bits below the mantissa: guard, round, and a sticky OR of everything lower.
            d     = e_big - e_sml;
            sh    = {m_sml, 14'd0} >> d;
            big14 = {m_big, 3'b000};
            sml14 = {sh[24:12], sh[11] | (|sh[10:0])};
            e_res = $signed({3'b000, e_big});
            if (same) begin
                sum = {1'b0, big14} + {1'b0, sml14};
                if (sum[14]) begin
                    norm  = {sum[14:2], sum[1] | sum[0]};
                    e_res = e_res + 8'sd1;
                end else begin
                    norm = sum[13:0];
                end
            end else begin
                diff = big14 - sml14;
                for (int i = 13; i >= 0; i--) begin
                    if (!found && diff[i]) begin
                        found = 1'b1;
                        lz    = 5'(13 - i);
                    end
                end
                norm  = diff << lz;
                e_res = e_res - $signed({3'b000, lz});
            end
            up     = norm[2] & (norm[1] | norm[0] | norm[3]);
            mant_r = {1'b0, norm[13:3]} + {11'd0, up};
            if (mant_r[11]) begin
                frac  = mant_r[10:1];
                e_res = e_res + 8'sd1;
            end else begin
                frac = mant_r[9:0];
            end
            if (!same && (diff == 14'd0)) begin
                res = 16'h0000;
            end else if (e_res >= 8'sd31) begin
                res = {s_big, OVF_MAG};
            end else if (e_res <= 8'sd0) begin
                res = 16'h0000;
            end else begin
                res = {s_big, e_res[4:0], frac};
            end
        end
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_ACC;
            acc_reg   <= 16'h0000;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = acc_reg;
        out_beats  = cnt_reg;
        case (state_reg)
            ST_ACC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_next = fp16_add(acc_reg, in_data);
                    if (cnt_reg != CNT_MAX) begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                    if (in_last) begin
                        state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                // The total is released here; accepting a new beat waits for the next cycle.
                if (out_ready) begin
                    state_next = ST_ACC;
                    acc_next   = 16'h0000;
                    cnt_next   = '0;
                end
            end
            default: state_next = ST_ACC;
        endcase
    end

endmodule

// File: tb/tb_sum_accum.sv
// tb_sum_accum: directed and randomized rows against a real-arithmetic FP16 row-sum model.
`timescale 1ns/1ps
module tb_sum_accum;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_last;
    logic [15:0]      in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic [CNT_W-1:0] out_beats;

    int n_checks = 0;
    int n_fail   = 0;
    int rows     = 0;
    logic rand_ready_en = 1'b0;

    logic        model_live = 1'b0;
    logic        m_hold     = 1'b0;
    logic [15:0] m_total    = 16'h0000;
    int          m_cnt      = 0;

    sum_accum #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_beats (out_beats)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference arithmetic on reals ----------------
    function automatic real pow2(input int k);
        real r;
        r = 1.0;
        if (k >= 0) repeat (k) r = r * 2.0;
        else repeat (-k) r = r / 2.0;
        return r;
    endfunction

    function automatic real f2r(input logic [15:0] h);
        real r;
        int  e;
        e = int'(h[14:10]);
        if (e == 0) return 0.0;
        r = real'(int'({1'b1, h[9:0]})) * pow2(e - 25);
        return h[15] ? -r : r;
    endfunction

    function automatic logic [15:0] ovf(input logic s);
`ifdef SUM_ACCUM_SAT_EN
        return {s, 15'h7BFF};
`else
        return {s, 15'h7C00};
`endif
    endfunction

    function automatic logic [15:0] r2f(input real x);
        logic s;
        real  v, q, fl, fr;
        int   e, mi;
        if (x == 0.0) return 16'h0000;
        s = (x < 0.0);
        v = s ? -x : x;
        if (v < pow2(-14)) return 16'h0000;
        e = -14;
        while (e < 17 && pow2(e + 1) <= v) e++;
        q  = v / pow2(e - 10);
        fl = $floor(q);
        fr = q - fl;
        mi = int'(fl);
        if (fr > 0.5 || (fr == 0.5 && (mi % 2) == 1)) mi++;
        if (mi == 2048) begin
            mi = 1024;
            e++;
        end
        if (e > 15) return ovf(s);
        return {s, 5'(e + 15), 10'(mi - 1024)};
    endfunction

    function automatic logic [15:0] model_add(input logic [15:0] a, input logic [15:0] b);
        logic an, bn, ai, bi;
        an = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
        bn = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
        ai = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
        bi = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
        if (an || bn) return 16'h7E00;
        if (ai && bi) return (a[15] == b[15]) ? a : 16'h7E00;
        if (ai) return a;
        if (bi) return b;
        if (a[14:10] == 5'd0 && b[14:10] == 5'd0) return {a[15] & b[15], 15'd0};
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [15:0] rand_fp16();
        logic [15:0] v;
        if ($urandom_range(0, 99) < 6) begin
            case ($urandom_range(0, 7))
                0: v = 16'h7C00;
                1: v = 16'hFC00;
                2: v = 16'h7E01;
                3: v = 16'h0001;
                4: v = 16'h8005;
                5: v = 16'h8000;
                6: v = 16'h7BFF;
                default: v = 16'hFBFF;
            endcase
        end else begin
            v = {1'($urandom_range(0, 1)), 5'($urandom_range(10, 20)), 10'($urandom_range(0, 1023))};
        end
        return v;
    endfunction

    // ---------------- row model: running total of accepted beats ----------------
    always @(posedge clk) begin
        if (rst) begin
            model_live <= 1'b1;
            m_hold     <= 1'b0;
            m_total    <= 16'h0000;
            m_cnt      <= 0;
        end else if (!m_hold) begin
            if (in_valid) begin
                m_total <= model_add(m_total, in_data);
                m_cnt   <= m_cnt + 1;
                if (in_last) m_hold <= 1'b1;
            end
        end else if (out_ready) begin
            m_hold  <= 1'b0;
            m_total <= 16'h0000;
            m_cnt   <= 0;
        end
    end

    always @(negedge clk) begin
        if (model_live && !rst) begin
            chk("in_ready", 32'(in_ready), 32'(!m_hold));
            chk("out_valid", 32'(out_valid), 32'(m_hold));
            if (m_hold) begin
                chk("out_data", 32'(out_data), 32'(m_total));
                chk("out_beats", 32'(out_beats), (m_cnt > CNT_MAX) ? CNT_MAX : m_cnt);
                if (out_ready) begin
                    rows++;
                    $display("row %0d: out_data=%h out_beats=%0d", rows, out_data, out_beats);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready_en) out_ready = ($urandom_range(0, 99) < 60);
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        logic rdy;
        int   waited;
        waited   = 0;
        rdy      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!rdy) begin
            @(negedge clk);
            rdy = in_ready;
            tick();
            if (!rdy) begin
                waited++;
                if (waited > 200) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL send_timeout: in_ready stayed %0b, expected 1 within 200 cycles", in_ready);
                    rdy = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic row_check(input string name, input logic [15:0] exp_data, input int exp_beats);
        @(negedge clk);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_data"}, 32'(out_data), 32'(exp_data));
        chk({name, "_beats"}, 32'(out_beats), exp_beats);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;

        // pin the reference arithmetic with hand-computed results
        chk("pin_add_136", 32'(model_add(16'h5080, 16'h5640)), 32'h5840);
        chk("pin_add_one", 32'(model_add(16'h0000, 16'h3C00)), 32'h3C00);
        chk("pin_cancel", 32'(model_add(16'h4000, 16'hC000)), 32'h0000);
`ifdef SUM_ACCUM_SAT_EN
        chk("pin_ovf", 32'(model_add(16'h7BFF, 16'h7BFF)), 32'h7BFF);
`else
        chk("pin_ovf", 32'(model_add(16'h7BFF, 16'h7BFF)), 32'h7C00);
`endif
        chk("pin_inf_minus_inf", 32'(model_add(16'h7C00, 16'hFC00)), 32'h7E00);
        chk("pin_nan", 32'(model_add(16'h7E01, 16'h3C00)), 32'h7E00);
        chk("pin_inf_fin", 32'(model_add(16'hFC00, 16'h3C00)), 32'hFC00);
        chk("pin_sub_res", 32'(model_add(16'h0400, 16'h8401)), 32'h0000);
        chk("pin_tie_even_dn", 32'(model_add(16'h3C00, 16'h1000)), 32'h3C00);
        chk("pin_tie_even_up", 32'(model_add(16'h3C01, 16'h1000)), 32'h3C02);
        chk("pin_exact_ulp", 32'(model_add(16'h3C00, 16'h1400)), 32'h3C01);

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'h0000);
        chk("reset_out_beats", 32'(out_beats), 32'd0);
        tick();

        send(16'h5080, 1'b0);
        send(16'h5640, 1'b1);
        row_check("two_beat", 16'h5840, 2);

        send(16'h3C00, 1'b1);
        row_check("one_beat", 16'h3C00, 1);

        send(16'h4000, 1'b0);
        send(16'hC000, 1'b1);
        row_check("cancel", 16'h0000, 2);

        send(16'h7BFF, 1'b0);
        send(16'h7BFF, 1'b1);
`ifdef SUM_ACCUM_SAT_EN
        row_check("overflow", 16'h7BFF, 2);
`else
        row_check("overflow", 16'h7C00, 2);
`endif

        // backpressure: a beat waits on in_valid throughout HOLD
        send(16'h4400, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'h4200;
        in_last  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_data", 32'(out_data), 32'h4400);
            chk("bp_out_beats", 32'(out_beats), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_after_hs_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        row_check("bp_next", 16'h4200, 1);

        send(16'h4400, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send(16'h3C00, 1'b1);
        row_check("rst_mid_row", 16'h3C00, 1);

        for (int i = 0; i < 260; i++) send(16'h3C00, (i == 259));
        row_check("cnt_sat", 16'h5C10, CNT_MAX);

        rand_ready_en = 1'b1;
        for (int r = 0; r < 200; r++) begin
            int len;
            len = $urandom_range(1, 8);
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 99) < 2) begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                end
                repeat ($urandom_range(0, 2)) begin
                    in_last = 1'($urandom_range(0, 1));
                    tick();
                end
                send(rand_fp16(), (b == len - 1));
            end
        end
        repeat (30) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sum_accum.md
SUM_ACCUM -- requirements
Module: sum_accum

Interface
REQ-001 Parameter: CNT_W, 8, width of the beat counter reported per row.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  in_data beat (one FP16 partial sum from the upstream add_tree) is presented.
REQ-005 in_last  input  1  qualifies the final beat of the current row; meaningful only with in_valid.
REQ-006 in_data  input  16  FP16 partial sum.
REQ-007 in_ready  output  1  block can accept a beat this cycle.
REQ-008 out_valid  output  1  row total is presented.
REQ-009 out_ready  input  1  downstream accepts the row total.
REQ-010 out_data  output  16  FP16 row total.
REQ-011 out_beats  output  CNT_W  number of beats accumulated into out_data.

Function
REQ-012 Two states: ACC (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-013 A beat transfers when in_valid && in_ready; at most one beat per cycle; no bubbles required between beats.
REQ-014 ACC transfer: acc <= fp16_add(acc, in_data), single cycle; cnt <= cnt+1, saturating at 2^CNT_W-1.
REQ-015 ACC transfer with in_last=1: same update, then next state HOLD; out_valid rises the cycle after the last beat is accepted (latency 1).
REQ-016 HOLD: out_data=acc, out_beats=cnt, both stable while out_valid && !out_ready.
REQ-017 HOLD with out_ready=1: next state ACC, acc <= +0 (0x0000), cnt <= 0; the next beat is accepted no earlier than the following cycle.
REQ-018 in_valid while in HOLD is ignored (not consumed); in_last without in_valid is ignored.
REQ-019 FP16 add: IEEE binary16, round-to-nearest-even, with guard/round/sticky bits.
REQ-020 Subnormal inputs are flushed to signed zero; subnormal results are flushed to +0.
REQ-021 Exact cancellation (x + -x) yields +0.
REQ-022 Any NaN operand, or +Inf + -Inf, yields canonical NaN 0x7E00; Inf + finite yields that Inf.
REQ-023 Finite overflow: behaviour per REQ-027/REQ-028.

Reset
REQ-024 While rst=1 at a clock edge: state <= ACC, acc <= 0x0000, cnt <= 0.
REQ-025 Output values after reset: in_ready=1, out_valid=0, out_data=0x0000, out_beats=0.
REQ-026 Reset asserted mid-row or during HOLD discards the partial or pending total; no out_valid is produced for that row.

Configuration
REQ-027 With macro SUM_ACCUM_SAT_EN defined, finite overflow saturates to the signed maximum finite value (0x7BFF or 0xFBFF).
REQ-028 Without SUM_ACCUM_SAT_EN, finite overflow produces signed infinity (0x7C00 or 0xFC00).

Verification
REQ-029 Two-beat row: 0x5080 (36.0), then 0x5640 (100.0) with in_last -> out_data=0x5840 (136.0), out_beats=2, out_valid one cycle after the last beat.
REQ-030 Single-beat row: 0x3C00 with in_last -> out_data=0x3C00, out_beats=1; next row starts from +0.
REQ-031 Cancellation: 0x4000, then 0xC000 with in_last -> out_data=0x0000, out_beats=2.
REQ-032 Overflow: 0x7BFF, then 0x7BFF with in_last -> out_data=0x7C00 without SUM_ACCUM_SAT_EN; out_data=0x7BFF with it.
REQ-033 Backpressure: out_ready held low for 5 cycles with in_valid=1 -> out_data/out_beats stable, in_ready=0, no beat consumed; the beat is accepted the cycle after the out_ready handshake.
REQ-034 Reset mid-row: 0x4400 accepted, rst pulsed, then 0x3C00 with in_last -> out_data=0x3C00, out_beats=1.
